osd_menu_render: RTL and testbench

OSD_MENU_RENDER -- requirements
Module: osd_menu_render

---
 rtl/osd_menu_render.sv | 164 ++++++++++++++++
 tb/tb_osd_menu_render.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_menu_render.sv
// Text-mode OSD overlay: prefetches one character cell ahead from a shared menu RAM
// (text buffer + font) and blends glyph pixels over the incoming video with a 2-clock lag.
module osd_menu_render #(
  parameter int          X0       = 64,
  parameter int          Y0       = 32,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        de_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [23:0] rgb_in,
  input  logic        menu_on,
  output logic [10:0] ram_adb,
  output logic        ram_ceb,
  output logic        ram_oceb,
  input  logic [7:0]  ram_dob,
  output logic        de_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic [23:0] rgb_out,
  output logic        osd_active
);

  // state  | meaning
  // F_IDLE | no fetch in flight for the upcoming cell
  // F_CHAR | char read issued, waiting for the code
  // F_FONT | font read issued, waiting for the glyph byte
  // F_HOLD | glyph byte ready, waiting to load the shifter
  typedef enum logic [1:0] {F_IDLE, F_CHAR, F_FONT, F_HOLD} fetch_state_e;

  localparam logic [10:0] FETCH_LO = 11'(X0 - 8);
  localparam logic [10:0] FETCH_HI = 11'(X0 + 247);
  localparam logic [10:0] WIN_X_LO = 11'(X0);
  localparam logic [10:0] WIN_X_HI = 11'(X0 + 255);
  localparam logic [9:0]  WIN_Y_LO = 10'(Y0);
  localparam logic [9:0]  WIN_Y_HI = 10'(Y0 + 127);

  fetch_state_e state_q;
  logic [10:0]  ram_adb_q;
  logic         ram_ceb_q;
  logic         code_inv_q;
  logic [7:0]   glyph_q;
  logic [7:0]   shift_q;
  logic         vs_prev_q;
  logic         live_q;
  logic         de1_q, hs1_q, vs1_q, act1_q, ovl1_q, pix1_q;
  logic [23:0]  rgb1_q;
  logic         de2_q, hs2_q, vs2_q, act2_q;
  logic [23:0]  rgb2_q;

  logic [2:0]   sub_d;
  logic [4:0]   fcol_d;
  logic [6:0]   dy_d;
  logic         in_y_d;
  logic         in_win_d;
  logic         fetch_ok_d;
  logic [10:0]  char_addr_d;
  logic [10:0]  font_addr_d;
  logic [23:0]  shade_d;

  assign sub_d       = x_in[2:0];
  assign fcol_d      = 5'((x_in - FETCH_LO) >> 3);
  assign dy_d        = 7'(y_in - WIN_Y_LO);
  assign in_y_d      = (y_in >= WIN_Y_LO) && (y_in <= WIN_Y_HI);
  assign in_win_d    = (x_in >= WIN_X_LO) && (x_in <= WIN_X_HI) && in_y_d;
  // The fetch span runs one cell ahead of the window, so it starts 8 pixels early.
  assign fetch_ok_d  = de_in && live_q && in_y_d && (x_in >= FETCH_LO) && (x_in <= FETCH_HI);
  assign char_addr_d = {2'b00, dy_d[6:3], fcol_d};
  assign font_addr_d = {1'b1, ram_dob[6:0], dy_d[2:0]};
  assign shade_d     = {1'b0, rgb1_q[23:17], 1'b0, rgb1_q[15:9], 1'b0, rgb1_q[7:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= F_IDLE;
      ram_adb_q  <= 11'd0;
      ram_ceb_q  <= 1'b0;
      code_inv_q <= 1'b0;
      glyph_q    <= 8'h00;
      shift_q    <= 8'h00;
      vs_prev_q  <= 1'b0;
      live_q     <= 1'b0;
      de1_q      <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      act1_q     <= 1'b0;
      ovl1_q     <= 1'b0;
      pix1_q     <= 1'b0;
      rgb1_q     <= 24'h0;
      de2_q      <= 1'b0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      act2_q     <= 1'b0;
      rgb2_q     <= 24'h0;
    end else begin
      vs_prev_q <= vs_in;
      if (vs_in && !vs_prev_q) live_q <= menu_on;

      ram_ceb_q <= 1'b0;
      // Any gap in the fetch conditions abandons the cell; the next sub=0 restarts cleanly.
      if (!fetch_ok_d) begin
        state_q <= F_IDLE;
      end else begin
        case (sub_d)
          3'd0: begin
            ram_adb_q <= char_addr_d;
            ram_ceb_q <= 1'b1;
            state_q   <= F_CHAR;
          end
          3'd2: begin
            if (state_q == F_CHAR) begin
              code_inv_q <= ram_dob[7];
              ram_adb_q  <= font_addr_d;
              ram_ceb_q  <= 1'b1;
              state_q    <= F_FONT;
            end else begin
              state_q <= F_IDLE;
            end
          end
          3'd4: begin
            if (state_q == F_FONT) begin
              glyph_q <= ram_dob ^ {8{code_inv_q}};
              state_q <= F_HOLD;
            end else begin
              state_q <= F_IDLE;
            end
          end
          3'd7:    state_q <= F_IDLE;
          default: state_q <= state_q;
        endcase
      end

      if (sub_d == 3'd7) shift_q <= (state_q == F_HOLD && fetch_ok_d) ? glyph_q : 8'h00;
      else               shift_q <= {1'b0, shift_q[7:1]};

      de1_q  <= de_in;
      hs1_q  <= hs_in;
      vs1_q  <= vs_in;
      rgb1_q <= rgb_in;
      act1_q <= live_q && in_win_d;
      ovl1_q <= live_q && in_win_d && de_in;
      pix1_q <= shift_q[0];

      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      act2_q <= act1_q;
      rgb2_q <= ovl1_q ? (pix1_q ? FG_COLOR : shade_d) : rgb1_q;
    end
  end

  assign ram_adb    = ram_adb_q;
  assign ram_ceb    = ram_ceb_q;
  assign ram_oceb   = 1'b1;
  assign de_out     = de2_q;
  assign hs_out     = hs2_q;
  assign vs_out     = vs2_q;
  assign rgb_out    = rgb2_q;
  assign osd_active = act2_q;

endmodule

// File: tb/tb_osd_menu_render.sv
// Directed bench for osd_menu_render: scans short video lines against a behavioural
// RAM and a pixel/read model, plus hand-computed pattern and address checks.
module tb_osd_menu_render;

  logic        clk;
  logic        resetn;
  logic        de_in, hs_in, vs_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [23:0] rgb_in;
  logic        menu_on;
  logic [10:0] ram_adb;
  logic        ram_ceb;
  logic        ram_oceb;
  logic [7:0]  ram_dob;
  logic        de_out, hs_out, vs_out;
  logic [23:0] rgb_out;
  logic        osd_active;

  osd_menu_render dut (
    .clk       (clk),
    .resetn    (resetn),
    .de_in     (de_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .rgb_in    (rgb_in),
    .menu_on   (menu_on),
    .ram_adb   (ram_adb),
    .ram_ceb   (ram_ceb),
    .ram_oceb  (ram_oceb),
    .ram_dob   (ram_dob),
    .de_out    (de_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .rgb_out   (rgb_out),
    .osd_active(osd_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  initial ram_dob = 8'h00;
  // Read registered on the enabled edge, data stable by the following edge.
  always @(posedge clk) if (ram_ceb) ram_dob <= mem[ram_adb];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  logic        live_m, vs_m, ok_h1, ok_h2;
  logic [31:0] exp_prev;
  logic        chk_prev;
  logic [10:0] x_prev;
  logic [9:0]  y_prev;
  int          n_ceb_line, n_act_line;
  logic        cap_pat, cap_adb;
  logic [7:0]  pat;
  logic [23:0] clr66;
  int          n_adb;
  logic [10:0] adb_seq [0:3];
  logic [10:0] adb_x   [0:3];

  function automatic logic exp_pix(input logic [10:0] x, input logic [9:0] y);
    int dx, dy, ca;
    logic [7:0] code, fb;
    dx = int'(x) - 64;
    dy = int'(y) - 32;
    ca = (dy / 8) * 32 + dx / 8;
    code = mem[ca];
    fb = mem[1024 + int'(code[6:0]) * 8 + dy % 8];
    if (code[7]) fb = ~fb;
    return fb[dx % 8];
  endfunction

  task automatic run_cycle(input logic [10:0] x, input logic [9:0] y, input logic de,
                           input logic hs, input logic vs, input logic [23:0] rgb,
                           input logic chk);
    logic ok, win, ovl, pix, eceb;
    logic [10:0] eadb;
    logic [23:0] half, ergb;
    logic [31:0] eout;
    logic [7:0]  code;
    int dy, ca;
    x_in = x; y_in = y; de_in = de; hs_in = hs; vs_in = vs; rgb_in = rgb;
    dy   = int'(y) - 32;
    ok   = resetn && live_m && de && x >= 56 && x <= 311 && y >= 32 && y <= 159;
    win  = resetn && live_m && x >= 64 && x <= 319 && y >= 32 && y <= 159;
    ovl  = win && de;
    pix  = ovl ? exp_pix(x, y) : 1'b0;
    half = {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
    ergb = ovl ? (pix ? 24'hFFFFFF : half) : rgb;
    eout = resetn ? {4'b0, de, hs, vs, win, ergb} : 32'h0;
    eceb = ok && (x[2:0] == 3'd0 || (x[2:0] == 3'd2 && ok_h1 && ok_h2));
    eadb = 11'd0;
    if (eceb) begin
      ca = (dy / 8) * 32 + (int'(x) - 56) / 8;
      if (x[2:0] == 3'd0) eadb = 11'(ca);
      else begin
        code = mem[ca];
        eadb = 11'(1024 + int'(code[6:0]) * 8 + dy % 8);
      end
    end
    @(posedge clk);
    #1;
    check_val($sformatf("ceb x=%0d y=%0d", x, y), {20'b0, ram_ceb, ram_ceb ? ram_adb : 11'd0},
              {20'b0, eceb, eadb});
    if (chk_prev)
      check_val($sformatf("out x=%0d y=%0d", x_prev, y_prev),
                {4'b0, de_out, hs_out, vs_out, osd_active, rgb_out}, exp_prev);
    if (ram_ceb) n_ceb_line++;
    if (osd_active) n_act_line++;
    if (cap_pat && x_prev >= 64 && x_prev <= 71) pat[x_prev - 64] = (rgb_out == 24'hFFFFFF);
    if (cap_pat && x_prev == 66) clr66 = rgb_out;
    if (cap_adb && x >= 80 && x <= 87 && ram_ceb && n_adb < 4) begin
      adb_seq[n_adb] = ram_adb;
      adb_x[n_adb]   = x;
      n_adb++;
    end
    exp_prev = eout;
    chk_prev = chk;
    x_prev   = x;
    y_prev   = y;
    ok_h2    = ok_h1;
    ok_h1    = ok;
    if (!resetn) begin
      live_m = 1'b0;
      vs_m   = 1'b0;
    end else begin
      if (vs && !vs_m) live_m = menu_on;
      vs_m = vs;
    end
  endtask

  task automatic run_line(input logic [9:0] y, input logic [23:0] rgb, input int gap_lo,
                          input int gap_hi, input int skip_lo, input int skip_hi, input int rel_x);
    n_ceb_line = 0;
    n_act_line = 0;
    for (int x = 0; x < 344; x++) begin
      if (x == rel_x) resetn = 1'b1;
      run_cycle(11'(x), y, (x < 330) && !(x >= gap_lo && x <= gap_hi), (x >= 334 && x <= 339),
                1'b0, rgb, !(x >= skip_lo && x <= skip_hi));
    end
  endtask

  task automatic run_vs_line();
    for (int x = 0; x < 344; x++)
      run_cycle(11'(x), 10'd0, 1'b0, 1'b0, (x >= 4 && x <= 20), 24'h0, 1'b1);
  endtask

  task automatic plain_line(input logic [9:0] y, input logic [23:0] rgb);
    run_line(y, rgb, 9999, -1, 9999, -1, -1);
  endtask

  initial begin
    resetn = 1'b0; menu_on = 1'b1;
    de_in = 0; hs_in = 0; vs_in = 0; x_in = 0; y_in = 0; rgb_in = 0;
    live_m = 0; vs_m = 0; ok_h1 = 0; ok_h2 = 0;
    exp_prev = 0; chk_prev = 0; x_prev = 0; y_prev = 0;
    cap_pat = 0; cap_adb = 0; pat = 0; clr66 = 0; n_adb = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i < 512)       mem[i] = 8'(i * 7 + 3);
      else if (i < 1024) mem[i] = 8'hEE;
      else               mem[i] = 8'(i * 37 + 11);
    end
    mem[0]     = 8'h41;
    mem[11'h60A] = 8'h33;
    mem[11'h40A] = 8'h33;
    mem[35]    = 8'h30;

    // Reset held through a vsync and an active window line.
    run_vs_line();
    plain_line(10'd40, 24'hABCDEF);
    check_val("rst_reads", 32'(n_ceb_line), 32'd0);
    check_val("rst_act", 32'(n_act_line), 32'd0);
    check_val("rst_oceb", {31'b0, ram_oceb}, 32'd1);
    check_val("rst_rgb", {8'b0, rgb_out}, 32'h0);

    // Release mid-line: no overlay until a vsync edge with menu_on.
    run_line(10'd34, 24'h123456, 9999, -1, 9999, -1, 150);
    check_val("post_rst_reads", 32'(n_ceb_line), 32'd0);

    run_vs_line();
    plain_line(10'd10, 24'h0F0F0F);
    check_val("above_reads", 32'(n_ceb_line), 32'd0);

    cap_pat = 1'b1;
    plain_line(10'd34, 24'h804020);
    cap_pat = 1'b0;
    check_val("pat_41", {24'b0, pat}, 32'h33);
    check_val("clear_px", {8'b0, clr66}, 32'h402010);
    check_val("line_reads", 32'(n_ceb_line), 32'd64);
    check_val("line_act", 32'(n_act_line), 32'd256);

    cap_adb = 1'b1; n_adb = 0;
    plain_line(10'd41, 24'h336699);
    cap_adb = 1'b0;
    check_val("cell3_n", 32'(n_adb), 32'd2);
    check_val("cell3_char", {21'b0, adb_seq[0]}, 32'h023);
    check_val("cell3_char_x", {21'b0, adb_x[0]}, 32'd80);
    check_val("cell3_font", {21'b0, adb_seq[1]}, 32'h581);
    check_val("cell3_font_x", {21'b0, adb_x[1]}, 32'd82);

    // de drops for 5 clocks mid-cell; the disturbed cell is not checked.
    run_line(10'd50, 24'h224466, 83, 87, 88, 95, -1);
    check_val("gap_reads", 32'(n_ceb_line), 32'd64);
    plain_line(10'd51, 24'h808080);

    mem[0] = 8'hC1;
    cap_pat = 1'b1;
    plain_line(10'd34, 24'h804020);
    cap_pat = 1'b0;
    check_val("pat_c1", {24'b0, pat}, 32'hCC);

    plain_line(10'd159, 24'h010203);
    check_val("last_row_act", 32'(n_act_line), 32'd256);
    plain_line(10'd160, 24'h010203);
    check_val("below_reads", 32'(n_ceb_line), 32'd0);
    check_val("below_act", 32'(n_act_line), 32'd0);

    menu_on = 1'b0;
    plain_line(10'd60, 24'h445566);
    check_val("persist_act", 32'(n_act_line), 32'd256);
    run_vs_line();
    plain_line(10'd34, 24'h804020);
    check_val("off_reads", 32'(n_ceb_line), 32'd0);
    check_val("off_act", 32'(n_act_line), 32'd0);

    menu_on = 1'b1;
    plain_line(10'd35, 24'h804020);
    check_val("midframe_on_act", 32'(n_act_line), 32'd0);
    run_vs_line();
    plain_line(10'd100, 24'hFEDCBA);
    check_val("reon_act", 32'(n_act_line), 32'd256);
    check_val("reon_reads", 32'(n_ceb_line), 32'd64);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
